// File: rtl/reset_request_filter.sv
// Conditions the reset-generator request: synchronises and debounces the reset button,
// glitch-filters PLL lock, stretches force_rst_n low, and keeps a sticky reset cause.
module reset_request_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1000,
  parameter int LOCK_FILTER = 16,
  parameter int PULSE_MIN   = 8,
  parameter int W_DB        = $clog2(DEBOUNCE + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n_async,
  input  logic       pll_locked_async,
  input  logic       cause_clr,
  output logic       force_rst_n,
  output logic       btn_pressed,
  output logic       lock_ok,
  output logic [1:0] rst_cause
);

  localparam int W_DBC = (W_DB < 1) ? 1 : W_DB;
  localparam int W_LK  = $clog2(LOCK_FILTER + 1);
  localparam int W_PC  = (PULSE_MIN < 1) ? 1 : $clog2(PULSE_MIN + 1);

  localparam logic [W_LK-1:0] LK_ONE  = W_LK'(1);
  localparam logic [W_LK-1:0] LK_LAST = W_LK'(LOCK_FILTER - 1);
  localparam logic [W_LK-1:0] LK_SAT  = W_LK'(LOCK_FILTER);
  localparam logic [W_PC-1:0] PC_ONE  = W_PC'(1);
  localparam logic [W_PC-1:0] PC_INIT = W_PC'(PULSE_MIN);

  typedef enum logic {
    ST_ASSERT = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   btn_s;
  logic                   lock_s;

  logic [W_LK-1:0] lock_ctr;
  logic [W_PC-1:0] pulse_ctr;
  logic [W_PC-1:0] pulse_next;
  logic [1:0]      cause_set;
  state_t          state;
  state_t          next_state;

  // Button idles released (high) and lock idles unlocked while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync  <= '1;
      lock_sync <= '0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_n_async};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_async};
    end
  end

  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE == 0) begin : g_no_debounce
      always_ff @(posedge clk) begin
        if (rst) btn_pressed <= 1'b0;
        else     btn_pressed <= ~btn_s;
      end
    end else begin : g_debounce
      localparam logic [W_DBC-1:0] DB_ONE  = W_DBC'(1);
      localparam logic [W_DBC-1:0] DB_LAST = W_DBC'(DEBOUNCE - 1);
      logic [W_DBC-1:0] db_ctr;

      // A change needs DEBOUNCE consecutive samples disagreeing with the current state.
      always_ff @(posedge clk) begin
        if (rst) begin
          db_ctr      <= '0;
          btn_pressed <= 1'b0;
        end else if (~btn_s != btn_pressed) begin
          if (db_ctr == DB_LAST) begin
            btn_pressed <= ~btn_pressed;
            db_ctr      <= '0;
          end else begin
            db_ctr <= db_ctr + DB_ONE;
          end
        end else begin
          db_ctr <= '0;
        end
      end
    end
  endgenerate

  // Lock loss is reported immediately; lock recovery must prove itself first.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_ctr <= '0;
      lock_ok  <= 1'b0;
    end else if (!lock_s) begin
      lock_ctr <= '0;
      lock_ok  <= 1'b0;
    end else begin
      if (lock_ctr != LK_SAT) lock_ctr <= lock_ctr + LK_ONE;
      if (lock_ctr >= LK_LAST) lock_ok <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    pulse_next = pulse_ctr;
    cause_set  = 2'b00;
    case (state)
      ST_ASSERT: begin
        if (pulse_ctr != '0) pulse_next = pulse_ctr - PC_ONE;
        if (pulse_ctr == '0 && lock_ok && !btn_pressed) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (btn_pressed || !lock_ok) begin
          next_state = ST_ASSERT;
          pulse_next = PC_INIT;
          cause_set  = {~lock_ok, btn_pressed};
        end
      end
    endcase
  end

  // A new cause overrides a simultaneous clear so the freshest event is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ASSERT;
      pulse_ctr   <= PC_INIT;
      force_rst_n <= 1'b0;
      rst_cause   <= 2'b00;
    end else begin
      state       <= next_state;
      pulse_ctr   <= pulse_next;
      force_rst_n <= (next_state == ST_RUN);
      if (cause_set != 2'b00)
        rst_cause <= cause_clr ? cause_set : (rst_cause | cause_set);
      else if (cause_clr)
        rst_cause <= 2'b00;
    end
  end

endmodule
